print_hex_stream: RTL

- Parametrised successor to the debug unit's print block.
- Accepts one print job per four-phase req/ack handshake: a DW-bit value plus a mode.
- Emits the value as a stream of 8-bit characters to the UART transmitter over a vld/rdy byte handshake.
- Adds generic width, latched operands, leading-zero suppression, optional CR/LF terminator, selectable hex case and back-pressure-safe streaming.

---
 rtl/print_hex_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/print_hex_stream.sv
// Prints one latched DW-bit value per req/ack job as raw byte or hex characters (optionally
// zero-suppressed or CR/LF terminated) over a vld/rdy byte stream; characters hold while rdy is low.
module print_hex_stream #(
  parameter int DW    = 32,
  parameter bit UPPER = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] dout_tx,
  input  logic [1:0]    mode_tx,
  input  logic          req_tx,
  output logic          ack_tx,
  output logic          busy,
  output logic [7:0]    d_tx,
  output logic          vld_tx,
  input  logic          rdy_tx
);

  localparam int ND = DW / 4;
  localparam int IW = $clog2(ND + 2);
  localparam logic [IW-1:0] LAST_HEX = IW'(ND - 1);
  localparam logic [IW-1:0] CR_POS   = IW'(ND);
  localparam logic [IW-1:0] LF_POS   = IW'(ND + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SEND, DONE} state_t;

  state_t        state;
  logic [DW-1:0] data_r;
  logic [1:0]    mode_r;
  logic [IW-1:0] index;
  logic [IW-1:0] last_idx;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Digit 0 is the most-significant nibble.
  function automatic logic [3:0] digit(input logic [DW-1:0] v, input logic [IW-1:0] i);
    logic [DW-1:0] sh;
    sh = v >> (4 * (ND - 1 - int'(i)));
    return sh[3:0];
  endfunction

  function automatic logic [7:0] char_at(input logic [IW-1:0] pos);
    logic [7:0] c;
    c = hex_char(digit(data_r, pos));
    if (mode_r == 2'b00)      c = data_r[7:0];
    else if (mode_r == 2'b11) begin
      if (pos == CR_POS)      c = 8'h0D;
      else if (pos == LF_POS) c = 8'h0A;
    end
    return c;
  endfunction

  always_comb begin
    last_idx = LAST_HEX;
    case (mode_r)
      2'b00:   last_idx = '0;
      2'b11:   last_idx = LF_POS;
      default: last_idx = LAST_HEX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      data_r <= '0;
      mode_r <= 2'b00;
      index  <= '0;
      ack_tx <= 1'b0;
      busy   <= 1'b0;
      vld_tx <= 1'b0;
      d_tx   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_tx) begin
            data_r <= dout_tx;
            mode_r <= mode_tx;
            busy   <= 1'b1;
            // The top nibble is tested here so suppression costs exactly one cycle per leading zero.
            if (mode_tx == 2'b10 && dout_tx[DW-1 -: 4] == 4'h0) begin
              state <= SKIP;
              index <= IW'(1);
            end else begin
              state  <= SEND;
              index  <= '0;
              vld_tx <= 1'b1;
              d_tx   <= (mode_tx == 2'b00) ? dout_tx[7:0] : hex_char(dout_tx[DW-1 -: 4]);
            end
          end
        end
        SKIP: begin
          if (digit(data_r, index) == 4'h0 && index < LAST_HEX) begin
            index <= index + 1'b1;
          end else begin
            state  <= SEND;
            vld_tx <= 1'b1;
            d_tx   <= hex_char(digit(data_r, index));
          end
        end
        SEND: begin
          if (vld_tx && rdy_tx) begin
            if (index == last_idx) begin
              vld_tx <= 1'b0;
              ack_tx <= req_tx;
              state  <= DONE;
            end else begin
              index <= index + 1'b1;
              d_tx  <= char_at(index + 1'b1);
            end
          end
        end
        DONE: begin
          if (!req_tx) begin
            ack_tx <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            ack_tx <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
